// File: rtl/dsi_hs_lane_aligner.sv
// rtl/dsi_hs_lane_aligner.sv - DSI HS 4-lane SoT sync hunt, lane deskew and byte alignment
// Optional feature macro DSI_ALIGN_ERR_CNT_EN adds a saturating sync_err counter on err_cnt.
module dsi_hs_lane_aligner #(
   parameter int         LANES     = 4,
   parameter logic [7:0] SYNC_BYTE = 8'hB8,
   parameter int         SKEW_MAX  = 3,
   parameter int         HUNT_TO   = 64
) (
   input  logic                 div_clk,
   input  logic                 rst,
   input  logic                 hs_req,
   input  logic [8*LANES-1:0]   lane_bits,
   output logic [8*LANES-1:0]   aligned_data,
   output logic                 aligned_valid,
   output logic                 hs_burst_flag,
   output logic [3*LANES-1:0]   lane_offset,
`ifdef DSI_ALIGN_ERR_CNT_EN
   output logic [15:0]          err_cnt,
`endif
   output logic                 sync_err
);
   localparam int SKW = $clog2(SKEW_MAX + 2);
   localparam int HTW = $clog2(HUNT_TO);

   typedef enum logic [1:0] {IDLE, HUNT, ALIGNED, WAIT_LP} state_t;
   state_t state, state_nxt;

   logic [7:0]     prev_byte [LANES];
   logic [15:0]    win       [LANES];
   logic [15:0]    win_sh    [LANES];
   logic [3:0]     hit_s     [LANES];
   logic [3:0]     lane_s    [LANES];
   logic [SKW-1:0] det_time  [LANES];
   logic [SKW-1:0] lane_dly  [LANES];
   logic [7:0]     extract   [LANES];
   logic [7:0]     dly_line  [LANES][SKEW_MAX];
   logic [LANES-1:0] hit, synced, det_now;
   logic [8*LANES-1:0] word_nxt;
   logic           first_seen;
   logic [SKW-1:0] skew_cnt, elapsed;
   logic [HTW-1:0] hunt_cnt;
   logic           any_det, all_synced_now, hunt_clr, go_aligned, err_now, emit;

   // Per-lane sync search over the 16-bit window; descending loop so the lowest s wins.
   always_comb begin
      word_nxt = '0;
      for (int k = 0; k < LANES; k++) begin
         win[k]   = {lane_bits[8*k +: 8], prev_byte[k]};
         hit[k]   = 1'b0;
         hit_s[k] = 4'd0;
         for (int s = 8; s >= 1; s--) begin
            if (win[k][s +: 8] == SYNC_BYTE) begin
               hit[k]   = 1'b1;
               hit_s[k] = 4'(s);
            end
         end
         det_now[k] = hit[k] && !synced[k] && (state == HUNT);
         win_sh[k]  = win[k] >> lane_s[k];
         extract[k] = win_sh[k][7:0];
         word_nxt[8*k +: 8] = extract[k];
         for (int i = 0; i < SKEW_MAX; i++) begin
            if (lane_dly[k] == SKW'(i + 1)) word_nxt[8*k +: 8] = dly_line[k][i];
         end
      end
   end

   assign any_det        = |det_now;
   assign all_synced_now = &(synced | det_now);
   assign elapsed        = first_seen ? skew_cnt : '0;
   assign emit           = (state == ALIGNED) && hs_req;

   always_ff @(posedge div_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      hunt_clr   = 1'b0;
      go_aligned = 1'b0;
      err_now    = 1'b0;
      case (state)
         IDLE: begin
            if (hs_req) begin
               state_nxt = HUNT;
               hunt_clr  = 1'b1;
            end
         end
         HUNT: begin
            // hs_req fall has priority over a same-cycle final detection.
            if (!hs_req) begin
               state_nxt = IDLE;
            end else if (all_synced_now && (elapsed <= SKW'(SKEW_MAX))) begin
               state_nxt  = ALIGNED;
               go_aligned = 1'b1;
            end else if (first_seen && (skew_cnt > SKW'(SKEW_MAX))) begin
               state_nxt = WAIT_LP;
               err_now   = 1'b1;
            end else if (!first_seen && !any_det && (hunt_cnt == HTW'(HUNT_TO - 1))) begin
               state_nxt = WAIT_LP;
               err_now   = 1'b1;
            end
         end
         ALIGNED: if (!hs_req) state_nxt = IDLE;
         WAIT_LP: if (!hs_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge div_clk) begin
      if (rst) begin
         synced        <= '0;
         first_seen    <= 1'b0;
         skew_cnt      <= '0;
         hunt_cnt      <= '0;
         lane_offset   <= '0;
         aligned_data  <= '0;
         aligned_valid <= 1'b0;
         hs_burst_flag <= 1'b0;
         sync_err      <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            prev_byte[k] <= '0;
            lane_s[k]    <= '0;
            det_time[k]  <= '0;
            lane_dly[k]  <= '0;
            for (int i = 0; i < SKEW_MAX; i++) dly_line[k][i] <= '0;
         end
      end else begin
         for (int k = 0; k < LANES; k++) begin
            prev_byte[k]   <= lane_bits[8*k +: 8];
            dly_line[k][0] <= extract[k];
            for (int i = 1; i < SKEW_MAX; i++) dly_line[k][i] <= dly_line[k][i-1];
         end
         if (hunt_clr) begin
            synced      <= '0;
            first_seen  <= 1'b0;
            skew_cnt    <= '0;
            hunt_cnt    <= '0;
            lane_offset <= '0;
         end else if (state == HUNT) begin
            for (int k = 0; k < LANES; k++) begin
               if (det_now[k]) begin
                  synced[k]           <= 1'b1;
                  lane_s[k]           <= hit_s[k];
                  det_time[k]         <= elapsed;
                  lane_offset[3*k +: 3] <= hit_s[k][2:0];
               end
               if (go_aligned) lane_dly[k] <= det_now[k] ? '0 : elapsed - det_time[k];
            end
            // skew_cnt tracks cycles since first detection, saturating one past the limit.
            if (first_seen) begin
               if (skew_cnt <= SKW'(SKEW_MAX)) skew_cnt <= skew_cnt + 1'b1;
            end else if (any_det) begin
               first_seen <= 1'b1;
               skew_cnt   <= SKW'(1);
            end
            if (!first_seen && !any_det) hunt_cnt <= hunt_cnt + 1'b1;
         end
         aligned_valid <= emit;
         hs_burst_flag <= emit;
         aligned_data  <= emit ? word_nxt : '0;
         sync_err      <= err_now;
      end
   end

`ifdef DSI_ALIGN_ERR_CNT_EN
   always_ff @(posedge div_clk) begin
      if (rst)                         err_cnt <= '0;
      else if (err_now && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
   end
`endif

endmodule
